// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between N byte requesters.
// Holds the granted byte, tracks the frame and guards it with a watchdog.
module uart_tx_arbiter #(
    parameter  int N       = 4,
    parameter  int TIMEOUT = 1024,
    localparam int TW      = $clog2(TIMEOUT + 1),
    localparam int GW      = $clog2(N)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [N-1:0]    req,
    input  logic [8*N-1:0]  req_data,
    output logic [N-1:0]    ack,
    output logic [N-1:0]    cpl,
    output logic            err,
    output logic            busy,
    output logic [GW-1:0]   grant_id,
    output logic            tx_valid,
    output logic [7:0]      tx_data,
    input  logic            tx_done,
    input  logic            tx_active
);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_DONE,
        DRAIN
    } state_t;

    state_t        state;
    logic [GW-1:0] rr;
    logic [TW-1:0] wd;
    logic [GW-1:0] win;
    logic          found;
    int            k;

    // First asserted request at or above the rr pointer, wrapping.
    always_comb begin
        win   = '0;
        found = 1'b0;
        k     = 0;
        for (int i = 0; i < N; i++) begin
            k = int'(rr) + i;
            if (k >= N) k = k - N;
            if (!found && req[GW'(k)]) begin
                win   = GW'(k);
                found = 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            ack      <= '0;
            cpl      <= '0;
            err      <= 1'b0;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            grant_id <= '0;
            rr       <= '0;
            wd       <= '0;
        end else begin
            ack      <= '0;
            cpl      <= '0;
            err      <= 1'b0;
            tx_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    // uart_tx has no reset: wait until it is truly idle.
                    if (found && !tx_active && !tx_done) begin
                        tx_data  <= req_data[{win, 3'b000} +: 8];
                        grant_id <= win;
                        ack      <= N'(1) << win;
                        tx_valid <= 1'b1;
                        state    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    wd    <= '0;
                    rr    <= (grant_id == GW'(N - 1)) ? '0 : grant_id + 1'b1;
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (tx_done) begin
                        cpl   <= N'(1) << grant_id;
                        state <= DRAIN;
                    end else if (wd == TW'(TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        state <= DRAIN;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                DRAIN: begin
                    if (!tx_done && !tx_active) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a hand-driven transmitter.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]  ack;
    logic [N-1:0]  cpl;
    logic          err;
    logic          busy;
    logic [1:0]    grant_id;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic          tx_done = 1'b0;
    logic          tx_active = 1'b0;

    int total = 0;
    int bad = 0;
    int n;
    logic saw_cpl;

    uart_tx_arbiter #(.N(N), .TIMEOUT(TO)) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .req(req),
        .req_data(req_data),
        .ack(ack),
        .cpl(cpl),
        .err(err),
        .busy(busy),
        .grant_id(grant_id),
        .tx_valid(tx_valid),
        .tx_data(tx_data),
        .tx_done(tx_done),
        .tx_active(tx_active)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One full frame from IDLE: grant, launch, done held 2 cycles, drain.
    task automatic do_frame(input int id, input logic [7:0] d,
                            input logic [3:0] drop, input logic [3:0] mid);
        step();
        chk("ack", 32'(ack), 32'(1) << id);
        chk("gid", 32'(grant_id), 32'(id));
        chk("txd", 32'(tx_data), 32'(d));
        chk("txv", 32'(tx_valid), 32'd1);
        chk("busy", 32'(busy), 32'd1);
        req = req & ~drop;
        tx_active = 1'b1;
        step();
        chk("ack_pulse", 32'(ack), 32'd0);
        chk("txv_pulse", 32'(tx_valid), 32'd0);
        req = req | mid;
        step();
        req = req & ~mid;
        tx_done = 1'b1;
        step();
        chk("cpl", 32'(cpl), 32'(1) << id);
        chk("no_err", 32'(err), 32'd0);
        step();
        chk("cpl_once", 32'(cpl), 32'd0);
        chk("busy_drain", 32'(busy), 32'd1);
        chk("txd_hold", 32'(tx_data), 32'(d));
        chk("no_relaunch", 32'(tx_valid), 32'd0);
        tx_done = 1'b0;
        tx_active = 1'b0;
        step();
        chk("idle", 32'(busy), 32'd0);
    endtask

    initial begin
        // Reset values
        step();
        step();
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_cpl", 32'(cpl), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_txv", 32'(tx_valid), 32'd0);
        chk("rst_txd", 32'(tx_data), 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd0);
        rst_n = 1'b1;
        step();

        // Single request from requester 1
        req_data = {8'h44, 8'h33, 8'hA5, 8'h11};
        req = 4'b0010;
        do_frame(1, 8'hA5, 4'b0010, 4'b0000);
        step();
        chk("single_quiet", 32'(ack), 32'd0);

        // All four requesting: order 0,1,2,3,0 from a fresh rr pointer
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        req = 4'b1111;
        for (int i = 0; i < 5; i++)
            do_frame(i % 4, 8'h11 * 8'((i % 4) + 1), 4'b0000, 4'b0000);

        // IDLE blocks while the transmitter is still busy
        tx_active = 1'b1;
        step();
        chk("guard_active", 32'(ack), 32'd0);
        tx_active = 1'b0;
        tx_done = 1'b1;
        step();
        chk("guard_done", 32'(ack), 32'd0);
        chk("guard_busy", 32'(busy), 32'd0);
        req = 4'b0000;
        tx_done = 1'b0;

        // Watchdog: rr=1, requester 2 wins, transmitter never finishes
        req = 4'b0100;
        step();
        chk("to_ack", 32'(ack), 32'b0100);
        req = 4'b0000;
        tx_active = 1'b1;
        n = 0;
        saw_cpl = 1'b0;
        while (n < 100 && !err) begin
            step();
            n++;
            if (cpl != 0) saw_cpl = 1'b1;
        end
        chk("to_cycles", 32'(n), 32'(TO + 1));
        chk("to_no_cpl", 32'(saw_cpl), 32'd0);
        step();
        chk("to_err_once", 32'(err), 32'd0);
        chk("to_drain", 32'(busy), 32'd1);
        tx_active = 1'b0;
        step();
        chk("to_idle", 32'(busy), 32'd0);

        // Next request still served after a timeout (rr=3 -> 0)
        req = 4'b0001;
        do_frame(0, 8'h11, 4'b0001, 4'b0000);

        // Done on the last watchdog cycle: completion beats timeout
        req = 4'b0010;
        step();
        chk("tie_ack", 32'(ack), 32'b0010);
        req = 4'b0000;
        tx_active = 1'b1;
        repeat (TO) step();
        chk("tie_pre_err", 32'(err), 32'd0);
        chk("tie_pre_busy", 32'(busy), 32'd1);
        tx_done = 1'b1;
        step();
        chk("tie_cpl", 32'(cpl), 32'b0010);
        chk("tie_err", 32'(err), 32'd0);
        step();
        chk("tie_err_late", 32'(err), 32'd0);
        tx_done = 1'b0;
        tx_active = 1'b0;
        step();

        // Requester 2 pulses req during requester 0's frame (rr=2)
        req = 4'b0001;
        do_frame(0, 8'h11, 4'b0001, 4'b0100);
        step();
        step();
        chk("wd_no_ack", 32'(ack), 32'd0);
        chk("wd_no_busy", 32'(busy), 32'd0);
        req = 4'b1100;
        do_frame(2, 8'h33, 4'b1100, 4'b0000);

        // Reset mid-frame with transmitter still running (rr=3 -> 1)
        req_data[15:8] = 8'hA5;
        req = 4'b0010;
        step();
        chk("mr_ack", 32'(ack), 32'b0010);
        tx_active = 1'b1;
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_txd", 32'(tx_data), 32'd0);
        chk("mr_gid", 32'(grant_id), 32'd0);
        chk("mr_txv", 32'(tx_valid), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("mr_block", 32'(ack), 32'd0);
        chk("mr_block_busy", 32'(busy), 32'd0);
        tx_done = 1'b1;
        step();
        chk("mr_no_cpl", 32'(cpl), 32'd0);
        chk("mr_still_idle", 32'(busy), 32'd0);
        tx_done = 1'b0;
        tx_active = 1'b0;
        do_frame(1, 8'hA5, 4'b0010, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
